// File: rtl/icache_fetch_unit_pkg.sv
// ==========================================================================
// icache_fetch_unit_pkg : shared widths, FSM encoding, address-split helpers
// Rev 1.0
// ==========================================================================
`default_nettype none

package icache_fetch_unit_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_INST_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REFILL = 2'd1,
    ST_DRAIN  = 2'd2
  } fetch_state_e;

  // Byte offset of the set index: word-in-line bits plus the 2 byte bits.
  function automatic int calc_off(input int line_words);
    return $clog2(line_words) + 2;
  endfunction

  function automatic int calc_idx(input int sets);
    return $clog2(sets);
  endfunction

  // Refill word counter width; kept at least 1 bit for single-word lines.
  function automatic int calc_word_w(input int line_words);
    return (line_words > 1) ? $clog2(line_words) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/icache_line_store.sv
// ==========================================================================
// icache_line_store : direct-mapped valid/tag/data arrays, combinational read
// Rev 1.0
// ==========================================================================
`default_nettype none

module icache_line_store #(
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 4,
  parameter int INST_W     = 32,
  parameter int TAG_W      = 22,
  parameter int IDX_W      = 6,
  parameter int WORD_W     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  rd_idx,
  input  logic [TAG_W-1:0]  rd_tag,
  input  logic [WORD_W-1:0] rd_word,
  output logic              hit,
  output logic [INST_W-1:0] rd_data,
  input  logic [IDX_W-1:0]  line_idx,
  input  logic              wr_en,
  input  logic [WORD_W-1:0] wr_word,
  input  logic [INST_W-1:0] wr_data,
  input  logic              inv_en,
  input  logic [TAG_W-1:0]  inv_tag,
  input  logic              val_en
);

  logic [SETS-1:0]   valid_q, valid_d;
  logic [TAG_W-1:0]  tag_q  [SETS];
  logic [TAG_W-1:0]  tag_d  [SETS];
  logic [INST_W-1:0] data_q [SETS][LINE_WORDS];
  logic [INST_W-1:0] data_d [SETS][LINE_WORDS];

  // Invalidate also installs the new tag so the line is claimed before refill.
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (inv_en) begin
      valid_d[line_idx] = 1'b0;
      tag_d[line_idx]   = inv_tag;
    end
    if (wr_en) begin
      data_d[line_idx][wr_word] = wr_data;
    end
    if (val_en) begin
      valid_d[line_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

  assign hit     = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign rd_data = data_q[rd_idx][rd_word];

endmodule

`default_nettype wire

// File: rtl/icache_fetch_unit.sv
// ==========================================================================
// icache_fetch_unit : fetch stage with direct-mapped I-cache and line refill
// Rev 1.0
// ==========================================================================
`default_nettype none

module icache_fetch_unit #(
  parameter int ADDR_W     = icache_fetch_unit_pkg::DEF_ADDR_W,
  parameter int INST_W     = icache_fetch_unit_pkg::DEF_INST_W,
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  output logic              mc_req,
  output logic [ADDR_W-1:0] mc_addr,
  input  logic              mc_valid,
  input  logic [INST_W-1:0] mc_data,
  output logic [INST_W-1:0] pdc_inst,
  output logic [ADDR_W-1:0] pdc_pc,
  input  logic              pdc_jump,
  input  logic [ADDR_W-1:0] pdc_imm,
  input  logic              iq_full,
  output logic              iq_valid,
  output logic [INST_W-1:0] iq_inst,
  output logic [ADDR_W-1:0] iq_pc,
  output logic              iq_pred_jump,
  output logic [ADDR_W-1:0] iq_pred_pc,
  input  logic              rb_flag,
  input  logic [ADDR_W-1:0] rb_pc
);

  import icache_fetch_unit_pkg::*;

  localparam int OFF    = calc_off(LINE_WORDS);
  localparam int IDX_W  = calc_idx(SETS);
  localparam int TAG_W  = ADDR_W - OFF - IDX_W;
  localparam int WORD_W = calc_word_w(LINE_WORDS);
  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(LINE_WORDS - 1);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              mc_req_q, mc_req_d;
  logic [ADDR_W-1:0] mc_addr_q, mc_addr_d;
  logic              iq_valid_q, iq_valid_d;
  logic [INST_W-1:0] iq_inst_q, iq_inst_d;
  logic [ADDR_W-1:0] iq_pc_q, iq_pc_d;
  logic              iq_pred_jump_q, iq_pred_jump_d;
  logic [ADDR_W-1:0] iq_pred_pc_q, iq_pred_pc_d;

  logic [IDX_W-1:0]  pc_idx;
  logic [TAG_W-1:0]  pc_tag;
  logic [WORD_W-1:0] pc_word;
  logic [ADDR_W-1:0] line_base;
  logic [ADDR_W-1:0] next_pc;
  logic [WORD_W-1:0] word_next;
  logic              ls_hit;
  logic [INST_W-1:0] ls_rd_data;
  logic              ls_wr_en;
  logic              ls_inv_en;
  logic              ls_val_en;

  assign pc_idx    = fetch_pc_q[OFF+IDX_W-1:OFF];
  assign pc_tag    = fetch_pc_q[ADDR_W-1:OFF+IDX_W];
  assign line_base = {fetch_pc_q[ADDR_W-1:OFF], {OFF{1'b0}}};
  assign next_pc   = pdc_jump ? (fetch_pc_q + pdc_imm) : (fetch_pc_q + ADDR_W'(4));
  assign word_next = word_q + WORD_W'(1);

  generate
    if (LINE_WORDS > 1) begin : g_word_multi
      assign pc_word = fetch_pc_q[OFF-1:2];
    end else begin : g_word_single
      assign pc_word = '0;
    end
  endgenerate

  // Fetch PC is frozen for the whole refill, so it also addresses the line being filled.
  icache_line_store #(
    .SETS       (SETS),
    .LINE_WORDS (LINE_WORDS),
    .INST_W     (INST_W),
    .TAG_W      (TAG_W),
    .IDX_W      (IDX_W),
    .WORD_W     (WORD_W)
  ) u_line_store (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (pc_idx),
    .rd_tag   (pc_tag),
    .rd_word  (pc_word),
    .hit      (ls_hit),
    .rd_data  (ls_rd_data),
    .line_idx (pc_idx),
    .wr_en    (ls_wr_en),
    .wr_word  (word_q),
    .wr_data  (mc_data),
    .inv_en   (ls_inv_en),
    .inv_tag  (pc_tag),
    .val_en   (ls_val_en)
  );

  always_comb begin
    state_d        = state_q;
    fetch_pc_d     = fetch_pc_q;
    word_d         = word_q;
    mc_req_d       = 1'b0;
    mc_addr_d      = mc_addr_q;
    iq_valid_d     = 1'b0;
    iq_inst_d      = iq_inst_q;
    iq_pc_d        = iq_pc_q;
    iq_pred_jump_d = iq_pred_jump_q;
    iq_pred_pc_d   = iq_pred_pc_q;
    ls_wr_en       = 1'b0;
    ls_inv_en      = 1'b0;
    ls_val_en      = 1'b0;

    if (rdy) begin
      if (rb_flag) begin
        fetch_pc_d = rb_pc;
        // A response arriving with the rollback leaves nothing outstanding.
        case (state_q)
          ST_REFILL: state_d = mc_valid ? ST_IDLE : ST_DRAIN;
          ST_DRAIN:  state_d = mc_valid ? ST_IDLE : ST_DRAIN;
          default:   state_d = ST_IDLE;
        endcase
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (ls_hit) begin
              if (!iq_full) begin
                iq_valid_d     = 1'b1;
                iq_inst_d      = ls_rd_data;
                iq_pc_d        = fetch_pc_q;
                iq_pred_jump_d = pdc_jump;
                iq_pred_pc_d   = next_pc;
                fetch_pc_d     = next_pc;
              end
            end else begin
              ls_inv_en = 1'b1;
              word_d    = '0;
              mc_req_d  = 1'b1;
              mc_addr_d = line_base;
              state_d   = ST_REFILL;
            end
          end
          ST_REFILL: begin
            if (mc_valid) begin
              ls_wr_en = 1'b1;
              if (word_q == LAST_WORD) begin
                ls_val_en = 1'b1;
                state_d   = ST_IDLE;
              end else begin
                word_d    = word_next;
                mc_req_d  = 1'b1;
                mc_addr_d = line_base |
                            ({{(ADDR_W-WORD_W){1'b0}}, word_next} << 2);
              end
            end
          end
          ST_DRAIN: begin
            if (mc_valid) begin
              state_d = ST_IDLE;
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      fetch_pc_q     <= RESET_PC;
      word_q         <= '0;
      mc_req_q       <= 1'b0;
      mc_addr_q      <= '0;
      iq_valid_q     <= 1'b0;
      iq_inst_q      <= '0;
      iq_pc_q        <= '0;
      iq_pred_jump_q <= 1'b0;
      iq_pred_pc_q   <= '0;
    end else begin
      state_q        <= state_d;
      fetch_pc_q     <= fetch_pc_d;
      word_q         <= word_d;
      mc_req_q       <= mc_req_d;
      mc_addr_q      <= mc_addr_d;
      iq_valid_q     <= iq_valid_d;
      iq_inst_q      <= iq_inst_d;
      iq_pc_q        <= iq_pc_d;
      iq_pred_jump_q <= iq_pred_jump_d;
      iq_pred_pc_q   <= iq_pred_pc_d;
    end
  end

  assign mc_req       = mc_req_q;
  assign mc_addr      = mc_addr_q;
  assign pdc_inst     = ls_hit ? ls_rd_data : '0;
  assign pdc_pc       = fetch_pc_q;
  assign iq_valid     = iq_valid_q;
  assign iq_inst      = iq_inst_q;
  assign iq_pc        = iq_pc_q;
  assign iq_pred_jump = iq_pred_jump_q;
  assign iq_pred_pc   = iq_pred_pc_q;

endmodule

`default_nettype wire

// File: doc/icache_fetch_unit.md
Name: icache_fetch_unit

Overview:
Instruction fetch stage with a parametrised direct-mapped I-cache and multi-word line refill from the memory controller (MC). It consults the branch predictor combinationally on every hit and pushes {inst, pc, predicted_jump, predicted_pc} into the instruction queue (IQ). A ROB rollback redirects the fetch PC. A rollback during a refill drains the outstanding MC response before fetch resumes. Refill continues while the IQ is full.

Parameters:
ADDR_W, 32, address width
INST_W, 32, instruction width
SETS, 64, cache lines; power of two, >=2
LINE_WORDS, 4, instructions per line; power of two, >=1
RESET_PC, 0, fetch PC after reset

Ports:
clk  in  1  clock
rst  in  1  reset
rdy  in  1  global enable; low freezes all state
mc_req  out  1  one-cycle word-fetch request pulse
mc_addr  out  ADDR_W  word address of request, bits[1:0]=0
mc_valid  in  1  one-cycle response pulse, only asserted while rdy=1
mc_data  in  INST_W  response word
pdc_inst  out  INST_W  hit instruction, 0 on miss
pdc_pc  out  ADDR_W  current fetch PC
pdc_jump  in  1  predictor says taken
pdc_imm  in  ADDR_W  predicted offset, sign-extended
iq_full  in  1  IQ cannot accept this cycle
iq_valid  out  1  one-cycle push pulse
iq_inst  out  INST_W  pushed instruction
iq_pc  out  ADDR_W  its PC
iq_pred_jump  out  1  predicted taken
iq_pred_pc  out  ADDR_W  predicted next PC
rb_flag  in  1  ROB rollback request
rb_pc  in  ADDR_W  rollback target PC

Interface decision: reset rst, synchronous, active-high; clock clk.

Behaviour:
- Address split: OFF=log2(LINE_WORDS)+2 bits. Index = pc[OFF+IDX-1:OFF] with IDX=log2(SETS). Tag = pc[ADDR_W-1:OFF+IDX]. Word-in-line = pc[OFF-1:2]. pc[1:0] is ignored.
- hit = valid[idx] && tag[idx]==pc tag. This is combinational. pdc_inst and pdc_pc are combinational from fetch_pc.
- next_pc = pdc_jump ? fetch_pc+pdc_imm : fetch_pc+4. The sum is modulo 2^ADDR_W and wraps silently.
- Reset: all valid bits cleared, fetch_pc=RESET_PC, state=IDLE. mc_req, iq_valid and iq_pred_jump are 0. mc_addr, iq_inst, iq_pc and iq_pred_pc are 0.
- rdy=0: no state, array or PC change. mc_req and iq_valid are 0 in the following cycle.
- Priority each enabled cycle: rb_flag > state action.
- States: IDLE, REFILL, DRAIN.
- IDLE, hit, !iq_full:
  - iq_valid=1 next cycle, carrying insts[idx][word], fetch_pc, pdc_jump and next_pc.
  - fetch_pc<=next_pc.
  - Throughput is one instruction per cycle.
- IDLE, hit, iq_full: hold fetch_pc, iq_valid=0.
- IDLE, miss, regardless of iq_full:
  - valid[idx]<=0, tag[idx]<=pc tag, word counter k<=0.
  - mc_req=1 with mc_addr={line base, k=0, 2'b00}.
  - Go to REFILL.
- REFILL:
  - Exactly one request is outstanding; mc_req is low while waiting.
  - On mc_valid: write insts[idx][k].
  - If k==LINE_WORDS-1: valid[idx]<=1, go to IDLE. The next cycle hits, so miss penalty = LINE_WORDS MC round trips + 1 cycle.
  - Otherwise k<=k+1 and mc_req=1 for the next word in the same cycle.
  - iq_valid=0 throughout.
- rb_flag in IDLE: fetch_pc<=rb_pc, iq_valid=0.
- rb_flag in REFILL: fetch_pc<=rb_pc, the line stays invalid, go to DRAIN. No further mc_req is issued.
- DRAIN: wait for mc_valid, discard the data, go to IDLE. rb_flag in DRAIN updates fetch_pc and stays in DRAIN.
- rb_flag and mc_valid in the same REFILL cycle: the data is discarded and the FSM goes directly to IDLE, since nothing is outstanding.
- Same-set conflict: a miss evicts the resident line unconditionally.
- Reset mid-refill: return to reset state. The MC is reset by the same rst, so no response arrives afterwards.

Decomposition:
- Shared package holds:
  - widths (ADDR_W, INST_W);
  - the FSM state encoding IDLE=0, REFILL=1, DRAIN=2;
  - functions or localparams deriving OFF and IDX from SETS and LINE_WORDS.
- One sub-module, icache_line_store, holds the valid/tag/data arrays. It has:
  - combinational hit and read-word outputs;
  - a per-word write port;
  - line invalidate and validate strobes.

Test Plan:
1. Reset, SETS=64, LINE_WORDS=4, MC latency 3 -> mc_req at addrs 0x0, 0x4, 0x8, 0xC with one outstanding at a time. Then iq_valid on 4 consecutive cycles with pc 0x0, 0x4, 0x8, 0xC, and the next mc_req at 0x10.
2. Cached line, pdc_jump=1, pdc_imm=0x10 at pc 0x4 -> iq_pred_jump=1, iq_pred_pc=0x14, next iq_pc=0x14 (miss if uncached).
3. iq_full held 5 cycles during hits -> no iq_valid, fetch_pc unchanged; release -> push resumes at the same pc. iq_full asserted at a miss -> refill still completes.
4. rb_flag=1, rb_pc=0x200 while word 2 is outstanding -> no further mc_req; DRAIN discards the response; next mc_req at 0x200. Refetch of 0x0 misses because the line is invalid.
5. Alternate fetch of 0x0 and 0x400 (same index) via rollback -> each access misses and refills 4 words. A rollback to 0x0 and mc_valid in the same cycle -> IDLE, no stale valid.
6. rdy=0 for 3 cycles mid-hit-stream and mid-REFILL -> no iq_valid or mc_req, PC and k unchanged; streaming resumes exactly where it stopped.
